fsm_general: RTL and testbench

FSM_GENERAL -- requirements
Module: fsm_general

---
 rtl/fsm_general.sv | 143 ++++++++++++++
 tb/tb_fsm_general.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fsm_general.sv
// -----------------------------------------------------------------------------
// fsm_general -- top-level sequencing FSM for the init / write / read engines.
//
// Walks a fixed cycle: init (b/c), optional user write (d/e), read (f/g),
// refresh dwell (h), then loops back to write or read. Each done-wait state
// (c/e/g) is guarded by a timeout that drops the machine into an error dwell
// (i), after which it performs a full re-init from state a.
//
// Ports:
//   clk       in   sole clock
//   reset     in   synchronous, active-high
//   fin_I     in   one-cycle done pulse from the init sequencer
//   fin_W     in   one-cycle done pulse from the write sequencer
//   fin_L     in   one-cycle done pulse from the read sequencer
//   prog_req  in   level request to write user-programmed data
//   ctrl_G    out  [3:0] registered state code for the general decoder
//   prog_ack  out  one-cycle pulse, coincident with entry to f after a write
//   busy      out  high while in states b..g
//   err       out  high while in state i
// -----------------------------------------------------------------------------
module fsm_general #(
  parameter int REFRESH_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 4095,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fin_I,
  input  logic       fin_W,
  input  logic       fin_L,
  input  logic       prog_req,
  output logic [3:0] ctrl_G,
  output logic       prog_ack,
  output logic       busy,
  output logic       err
);

  // State encoding doubles as the ctrl_G code, so the output is the register.
  typedef enum logic [3:0] {
    S_A = 4'd0,  // reset / idle, one cycle
    S_B = 4'd1,  // init start
    S_C = 4'd2,  // wait fin_I
    S_D = 4'd3,  // write start
    S_E = 4'd4,  // wait fin_W
    S_F = 4'd5,  // read start
    S_G = 4'd6,  // wait fin_L
    S_H = 4'd7,  // refresh dwell
    S_I = 4'd8   // error dwell
  } state_t;

  // Counter values on the last cycle of a dwell / timeout window. The counter
  // starts at 0 on state entry, so N cycles end when it reads N-1.
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             prog_ack_nx, busy_nx, err_nx;
  logic             counting;
  logic             tmo_hit;
  logic             ref_hit;

  assign counting = (state == S_C) || (state == S_E) || (state == S_G) ||
                    (state == S_H) || (state == S_I);
  assign tmo_hit  = (cnt == TMO_LAST);
  assign ref_hit  = (cnt == REF_LAST);

  // ---------------------------------------------------------------------------
  // State register (also holds the counter and the registered outputs so they
  // change on the same edge as ctrl_G).
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_A;
      cnt      <= '0;
      prog_ack <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      prog_ack <= prog_ack_nx;
      busy     <= busy_nx;
      err      <= err_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. A done pulse beats a coincident timeout because the
  // done test is evaluated first. Done pulses that do not belong to the
  // current wait state are simply not looked at.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default on entry so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      S_A: state_nx = S_B;
      S_B: state_nx = S_C;
      S_C: begin
        if (fin_I)        state_nx = prog_req ? S_D : S_F;
        else if (tmo_hit) state_nx = S_I;
      end
      S_D: state_nx = S_E;
      S_E: begin
        if (fin_W)        state_nx = S_F;
        else if (tmo_hit) state_nx = S_I;
      end
      S_F: state_nx = S_G;
      S_G: begin
        if (fin_L)        state_nx = S_H;
        else if (tmo_hit) state_nx = S_I;
      end
      S_H: if (ref_hit) state_nx = prog_req ? S_D : S_F;
      S_I: if (ref_hit) state_nx = S_A;
      default: state_nx = S_A;  // unreachable codes recover via re-init
    endcase
  end

  // Wait counter: cleared on any state change, saturates instead of wrapping.
  always_comb begin
    cnt_nx = cnt;
    if (state_nx != state)              cnt_nx = '0;
    else if (counting && cnt != CNT_MAX) cnt_nx = cnt + CNT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Output logic: decoded from the next state so the registered flags line up
  // with the registered ctrl_G on the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    prog_ack_nx = (state == S_E) && fin_W;
    busy_nx     = (state_nx == S_B) || (state_nx == S_C) || (state_nx == S_D) ||
                  (state_nx == S_E) || (state_nx == S_F) || (state_nx == S_G);
    err_nx      = (state_nx == S_I);
  end

  assign ctrl_G = state;

endmodule

// File: tb/tb_fsm_general.sv
// -----------------------------------------------------------------------------
// tb_fsm_general -- directed scoreboard bench for fsm_general
// (REFRESH_CYCLES=4, TIMEOUT_CYCLES=8).
//
// The stimulus process drives one cycle of inputs per step and, after the
// clock edge, queues the hand-computed observable state for that edge. A
// separate monitor pops one entry each falling edge and compares it against
// ctrl_G / prog_ack / busy / err.
// -----------------------------------------------------------------------------
module tb_fsm_general;

  localparam logic [3:0] A = 4'h0, B = 4'h1, C = 4'h2, D = 4'h3, E = 4'h4;
  localparam logic [3:0] F = 4'h5, G = 4'h6, H = 4'h7, I = 4'h8;

  typedef struct packed {
    logic [3:0] code;
    logic       ack;
    logic       busy;
    logic       err;
  } obs_t;

  typedef struct {
    int   step;
    obs_t obs;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       fin_I, fin_W, fin_L, prog_req;
  logic [3:0] ctrl_G;
  logic       prog_ack, busy, err;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   step_no = 0;

  fsm_general #(
    .REFRESH_CYCLES(4),
    .TIMEOUT_CYCLES(8),
    .CNT_W         (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .fin_I   (fin_I),
    .fin_W   (fin_W),
    .fin_L   (fin_L),
    .prog_req(prog_req),
    .ctrl_G  (ctrl_G),
    .prog_ack(prog_ack),
    .busy    (busy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Expected flags follow the state code: busy in b..g, err in i.
  function automatic obs_t model(input logic [3:0] code, input logic ack);
    obs_t o;
    o.code = code;
    o.ack  = ack;
    o.busy = (code >= B) && (code <= G);
    o.err  = (code == I);
    return o;
  endfunction

  // One clock of stimulus; code/ack describe the state visible after the edge.
  task automatic go(input logic rst, input logic fi, input logic fw,
                    input logic fl, input logic pr,
                    input logic [3:0] code, input logic ack);
    exp_t e;
    @(negedge clk);
    reset    = rst;
    fin_I    = fi;
    fin_W    = fw;
    fin_L    = fl;
    prog_req = pr;
    @(posedge clk);
    step_no++;
    e.step = step_no;
    e.obs  = model(code, ack);
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are registered, so a new value is presented every cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      obs_t act;
      e   = exp_q.pop_front();
      act = '{code: ctrl_G, ack: prog_ack, busy: busy, err: err};
      check($sformatf("step%0d{ctrl_G,ack,busy,err}", e.step),
            32'(act), 32'(e.obs));
    end
  end

  initial begin
    reset = 1'b1; fin_I = 1'b0; fin_W = 1'b0; fin_L = 1'b0; prog_req = 1'b0;

    // Reset, then a->b->c with no input help; fin_I on the 3rd c cycle.
    go(1, 0, 0, 0, 0, A, 0);
    go(0, 0, 0, 0, 0, B, 0);
    go(0, 0, 0, 0, 0, C, 0);
    go(0, 0, 0, 0, 0, C, 0);
    go(0, 0, 0, 0, 0, C, 0);
    go(0, 1, 0, 0, 0, F, 0);
    go(0, 0, 0, 0, 0, G, 0);

    // fin_L -> four h cycles; a prog_req blip mid-h is not sampled; the
    // request on the last h cycle sends us to d.
    go(0, 0, 0, 1, 0, H, 0);
    go(0, 0, 0, 0, 1, H, 0);
    go(0, 0, 0, 0, 0, H, 0);
    go(0, 0, 0, 0, 0, H, 0);
    go(0, 0, 0, 0, 1, D, 0);

    // Write: fin_W in e -> f with a single-cycle prog_ack.
    go(0, 0, 0, 0, 0, E, 0);
    go(0, 0, 0, 0, 0, E, 0);
    go(0, 0, 1, 0, 0, F, 1);
    go(0, 0, 0, 0, 0, G, 0);

    // Read again; foreign done pulses in h are ignored; no request -> f.
    go(0, 0, 0, 1, 0, H, 0);
    go(0, 1, 1, 1, 0, H, 0);
    go(0, 0, 0, 0, 0, H, 0);
    go(0, 0, 0, 0, 0, H, 0);
    go(0, 0, 0, 0, 0, F, 0);
    go(0, 0, 0, 0, 0, G, 0);
    go(0, 0, 0, 1, 0, H, 0);
    go(0, 0, 0, 0, 0, H, 0);
    go(0, 0, 0, 0, 0, H, 0);
    go(0, 0, 0, 0, 0, H, 0);
    go(0, 0, 0, 0, 1, D, 0);
    go(0, 0, 0, 0, 0, E, 0);

    // Reset in e with fin_W on the same edge: back to a, no prog_ack.
    go(1, 0, 1, 0, 0, A, 0);
    go(0, 0, 0, 0, 0, B, 0);

    // c timeout: 8 c cycles (fin_L ignored in one), then 4 i cycles, then a.
    go(0, 0, 0, 0, 0, C, 0);
    go(0, 0, 0, 1, 0, C, 0);
    for (int k = 0; k < 6; k++) go(0, 0, 0, 0, 0, C, 0);
    go(0, 0, 0, 0, 0, I, 0);
    go(0, 0, 0, 0, 1, I, 0);
    go(0, 0, 0, 0, 0, I, 0);
    go(0, 0, 0, 0, 0, I, 0);
    go(0, 0, 0, 0, 0, A, 0);
    go(0, 0, 0, 0, 0, B, 0);

    // fin_I on the 8th c cycle beats the timeout; prog_req=1 -> d, no err.
    go(0, 0, 0, 0, 0, C, 0);
    for (int k = 0; k < 7; k++) go(0, 0, 0, 0, 0, C, 0);
    go(0, 1, 0, 0, 1, D, 0);
    go(0, 0, 0, 0, 0, E, 0);

    // Let the monitor drain the last entry, then confirm nothing is left.
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
